// File: rtl/dtmr_mismatch_monitor.sv
// Health monitor for triplicated registers: per-copy mismatch counters
// against the voted value, threshold reporting via valid/ack, multi-fault flag.
module dtmr_mismatch_monitor #(
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] copy_in_0,
  input  logic [WIDTH-1:0] copy_in_1,
  input  logic [WIDTH-1:0] copy_in_2,
  input  logic [WIDTH-1:0] voted_in,
  input  logic             sample_en,
  output logic [CNT_W-1:0] err_cnt_0,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic             fault_valid,
  output logic [1:0]       fault_id,
  input  logic             fault_ack,
  output logic             multi_fault
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TH   = CNT_W'(THRESH);

  typedef enum logic {IDLE, REPORT} state_t;

  state_t                  state_q;
  logic [1:0]              id_q;
  logic [1:0]              id_d;
  logic                    mf_q;
  logic [2:0][CNT_W-1:0]   cnt_q;
  logic [2:0][CNT_W-1:0]   cnt_d;
  logic [2:0]              mis;
  logic [2:0]              hit;
  logic                    multi;
  logic                    ack_clr;

  assign mis[0] = |(copy_in_0 ^ voted_in);
  assign mis[1] = |(copy_in_1 ^ voted_in);
  assign mis[2] = |(copy_in_2 ^ voted_in);

  assign multi = (mis[0] & mis[1]) |
                 (mis[0] & mis[2]) |
                 (mis[1] & mis[2]);

  assign hit[0] = cnt_q[0] >= TH;
  assign hit[1] = cnt_q[1] >= TH;
  assign hit[2] = cnt_q[2] >= TH;

  assign ack_clr = (state_q == REPORT) && fault_ack;

  // The acknowledged copy is cleared even if it mismatches this cycle.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sample_en && mis[i] && (cnt_q[i] != CMAX))
        cnt_d[i] = cnt_q[i] + 1'b1;
      if (ack_clr && (id_q == 2'(i)))
        cnt_d[i] = '0;
    end
  end

  always_comb begin
    id_d = 2'd0;
    priority case (1'b1)
      hit[0]:  id_d = 2'd0;
      hit[1]:  id_d = 2'd1;
      hit[2]:  id_d = 2'd2;
      default: id_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      mf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (sample_en && multi)
        mf_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (|hit) begin
            state_q <= REPORT;
            id_q    <= id_d;
          end
        end
        REPORT: begin
          if (fault_ack)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err_cnt_0   = cnt_q[0];
  assign err_cnt_1   = cnt_q[1];
  assign err_cnt_2   = cnt_q[2];
  assign fault_valid = (state_q == REPORT);
  assign fault_id    = id_q;
  assign multi_fault = mf_q;

endmodule

// File: tb/tb_dtmr_mismatch_monitor.sv
// Bench for dtmr_mismatch_monitor: directed vector table on a default
// instance, saturation and randomized model checks on a narrow-counter one.
module tb_dtmr_mismatch_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=1, CNT_W=8, THRESH=4
  logic       a_rst, a_en, a_ack;
  logic       a_c0, a_c1, a_c2, a_v;
  logic [7:0] a_cnt0, a_cnt1, a_cnt2;
  logic       a_fv, a_mf;
  logic [1:0] a_id;

  // Instance B: WIDTH=4, CNT_W=3, THRESH=7
  localparam int B_MAX = 7;
  localparam int B_TH  = 7;
  logic       b_rst, b_en, b_ack;
  logic [3:0] b_c0, b_c1, b_c2, b_v;
  logic [2:0] b_cnt0, b_cnt1, b_cnt2;
  logic       b_fv, b_mf;
  logic [1:0] b_id;

  dtmr_mismatch_monitor #(.WIDTH(1), .CNT_W(8), .THRESH(4)) u_a (
    .clk(clk), .rst(a_rst),
    .copy_in_0(a_c0), .copy_in_1(a_c1), .copy_in_2(a_c2),
    .voted_in(a_v), .sample_en(a_en),
    .err_cnt_0(a_cnt0), .err_cnt_1(a_cnt1), .err_cnt_2(a_cnt2),
    .fault_valid(a_fv), .fault_id(a_id), .fault_ack(a_ack),
    .multi_fault(a_mf)
  );

  dtmr_mismatch_monitor #(.WIDTH(4), .CNT_W(3), .THRESH(7)) u_b (
    .clk(clk), .rst(b_rst),
    .copy_in_0(b_c0), .copy_in_1(b_c1), .copy_in_2(b_c2),
    .voted_in(b_v), .sample_en(b_en),
    .err_cnt_0(b_cnt0), .err_cnt_1(b_cnt1), .err_cnt_2(b_cnt2),
    .fault_valid(b_fv), .fault_id(b_id), .fault_ack(b_ack),
    .multi_fault(b_mf)
  );

  typedef struct {
    int rst; int en; int ack;
    int c0; int c1; int c2; int v;
    int e0; int e1; int e2; int ev; int eid; int emf;
  } vec_t;

  vec_t tv[$];
  int n_chk;
  int n_fail;

  // Reference model for instance B
  int m_cnt[3];
  int m_rep;
  int m_id;
  int m_mf;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_b();
    int nc[3];
    int nm;
    int mm[3];
    mm[0] = (b_c0 != b_v) ? 1 : 0;
    mm[1] = (b_c1 != b_v) ? 1 : 0;
    mm[2] = (b_c2 != b_v) ? 1 : 0;
    if (b_rst) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_rep = 0;
      m_id  = 0;
      m_mf  = 0;
    end else begin
      nm = 0;
      for (int i = 0; i < 3; i++) begin
        nc[i] = m_cnt[i];
        if (b_en && mm[i] == 1) begin
          nm++;
          if (nc[i] < B_MAX) nc[i]++;
        end
      end
      if (m_rep == 1) begin
        if (b_ack) begin
          m_rep = 0;
          nc[m_id] = 0;
        end
      end else begin
        for (int i = 2; i >= 0; i--)
          if (m_cnt[i] >= B_TH) begin
            m_rep = 1;
            m_id  = i;
          end
      end
      if (b_en && nm >= 2) m_mf = 1;
      for (int i = 0; i < 3; i++) m_cnt[i] = nc[i];
    end
  endtask

  task automatic check_b(input string tag);
    chk({tag, "_cnt0"}, int'(b_cnt0), m_cnt[0]);
    chk({tag, "_cnt1"}, int'(b_cnt1), m_cnt[1]);
    chk({tag, "_cnt2"}, int'(b_cnt2), m_cnt[2]);
    chk({tag, "_valid"}, int'(b_fv), m_rep);
    chk({tag, "_multi"}, int'(b_mf), m_mf);
    if (m_rep == 1) chk({tag, "_id"}, int'(b_id), m_id);
  endtask

  task automatic tick();
    @(posedge clk);
    model_b();
    @(negedge clk);
  endtask

  initial begin
    vec_t t;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_rep = 0; m_id = 0; m_mf = 0;
    a_rst = 1; a_en = 0; a_ack = 0;
    a_c0 = 0; a_c1 = 0; a_c2 = 0; a_v = 0;
    b_rst = 1; b_en = 0; b_ack = 0;
    b_c0 = 0; b_c1 = 0; b_c2 = 0; b_v = 0;

    //            rst en ack c0 c1 c2 v   e0 e1 e2 ev id mf
    tv.push_back('{1, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 1, 1,  0, 1, 1, 0,  0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  0, 1, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  0, 2, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  0, 3, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  0, 4, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0,  0, 1, 0, 0,  0, 4, 0, 1, 1, 0});
    tv.push_back('{0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0,  1, 0, 1, 0,  1, 0, 1, 0, 0, 1});
    tv.push_back('{0, 1, 0,  1, 0, 1, 0,  2, 0, 2, 0, 0, 1});
    tv.push_back('{0, 1, 0,  1, 0, 1, 0,  3, 0, 3, 0, 0, 1});
    tv.push_back('{0, 1, 0,  1, 0, 1, 0,  4, 0, 4, 0, 0, 1});
    tv.push_back('{0, 0, 0,  0, 0, 0, 0,  4, 0, 4, 1, 0, 1});
    tv.push_back('{0, 0, 1,  0, 0, 0, 0,  0, 0, 4, 0, 0, 1});
    tv.push_back('{0, 0, 0,  0, 0, 0, 0,  0, 0, 4, 1, 2, 1});
    tv.push_back('{0, 1, 1,  1, 0, 1, 0,  1, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  1, 1, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  1, 2, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  1, 3, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  1, 4, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  0, 1, 0, 0,  1, 5, 0, 1, 1, 1});
    tv.push_back('{0, 1, 1,  0, 1, 0, 0,  1, 0, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0,  1, 1, 1, 0,  1, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  1, 0, 0, 0,  2, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  1, 0, 0, 0,  3, 0, 0, 0, 0, 1});
    tv.push_back('{0, 1, 0,  1, 0, 0, 0,  4, 0, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0,  1, 0, 0, 0,  4, 0, 0, 1, 0, 1});
    tv.push_back('{1, 1, 0,  1, 1, 1, 0,  0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0});

    @(negedge clk);
    foreach (tv[k]) begin
      t = tv[k];
      a_rst = t.rst[0];
      a_en  = t.en[0];
      a_ack = t.ack[0];
      a_c0  = t.c0[0];
      a_c1  = t.c1[0];
      a_c2  = t.c2[0];
      a_v   = t.v[0];
      if (t.rst != 0) begin
        a_c0 = 1'($urandom);
        a_c1 = 1'($urandom);
        a_c2 = 1'($urandom);
        a_v  = 1'($urandom);
      end
      tick();
      chk($sformatf("vec%0d_cnt0", k), int'(a_cnt0), t.e0);
      chk($sformatf("vec%0d_cnt1", k), int'(a_cnt1), t.e1);
      chk($sformatf("vec%0d_cnt2", k), int'(a_cnt2), t.e2);
      chk($sformatf("vec%0d_valid", k), int'(a_fv), t.ev);
      chk($sformatf("vec%0d_multi", k), int'(a_mf), t.emf);
      if (t.ev != 0)
        chk($sformatf("vec%0d_id", k), int'(a_id), t.eid);
    end

    // Saturation: copy 0 mismatches for 12 samples with no ack
    b_rst = 1;
    tick();
    check_b("sat_rst");
    b_rst = 0; b_en = 1; b_ack = 0;
    b_v = 4'h0; b_c0 = 4'h5; b_c1 = 4'h0; b_c2 = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_b($sformatf("sat%0d", k));
      chk($sformatf("sat%0d_cnt0_hand", k), int'(b_cnt0), (k > 7) ? 7 : k);
    end
    chk("sat_end_valid", int'(b_fv), 1);
    chk("sat_end_id", int'(b_id), 0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      b_rst = ($urandom_range(49, 0) == 0);
      b_en  = ($urandom_range(4, 0) != 0);
      b_ack = ($urandom_range(2, 0) == 0);
      b_v   = 4'($urandom);
      b_c0  = ($urandom_range(2, 0) == 0) ? b_v ^ 4'($urandom_range(15, 1)) : b_v;
      b_c1  = ($urandom_range(3, 0) == 0) ? b_v ^ 4'($urandom_range(15, 1)) : b_v;
      b_c2  = ($urandom_range(4, 0) == 0) ? b_v ^ 4'($urandom_range(15, 1)) : b_v;
      tick();
      check_b($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
